// File: rtl/flash_spi_reader.sv
// SPI-NOR READ (0x03) controller serving the boot loader's word-fetch port.
// Sequential word fetches keep cs_n low and clock out only the 32 data bits.
module flash_spi_reader #(
  parameter int CLK_DIV     = 2,
  parameter int CS_IDLE_MAX = 16,
  parameter int CS_HIGH_MIN = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        flash_cycle,
  input  logic [31:0] flash_addr,
  output logic        flash_ack,
  output logic [31:0] flash_data,
  output logic        spi_sclk,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  // state | meaning
  // IDLE  | cs_n high, no open read stream
  // GAP   | cs_n high, waiting out CS_HIGH_MIN before a fresh command
  // SHIFT | serial transfer (64 bits fresh, 32 bits continuation)
  // ACK   | flash_ack pulse, flash_data just updated
  // DROP  | waiting for the requester to release flash_cycle
  // HELD  | cs_n low, sclk low, stream parked for a sequential fetch
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GAP   = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_ACK   = 3'd3;
  localparam logic [2:0] S_DROP  = 3'd4;
  localparam logic [2:0] S_HELD  = 3'd5;

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDLE_W = (CS_IDLE_MAX > 1) ? $clog2(CS_IDLE_MAX) : 1;
  localparam int GAP_W  = $clog2(CS_HIGH_MIN + 1);

  localparam logic [DIV_W-1:0]  DIV_RELOAD  = DIV_W'(CLK_DIV - 1);
  localparam logic [IDLE_W-1:0] IDLE_RELOAD = IDLE_W'(CS_IDLE_MAX - 1);
  localparam logic [GAP_W-1:0]  GAP_DONE    = GAP_W'(CS_HIGH_MIN);

  logic [2:0]        state;
  logic [DIV_W-1:0]  div_cnt;
  logic [5:0]        bit_cnt;
  logic [31:0]       cmd_sr;
  logic [31:0]       rx_sr;
  logic [21:0]       cur_word;
  logic [21:0]       next_word;
  logic              held_valid;
  logic [IDLE_W-1:0] idle_cnt;
  logic [GAP_W-1:0]  gap_cnt;

  logic [21:0] req_word;
  logic [31:0] fresh_cmd;
  logic        gap_ok;
  logic        seq_hit;
  logic        unused_addr_bits;

  assign req_word         = flash_addr[23:2];
  assign fresh_cmd        = {8'h03, req_word, 2'b00};
  assign gap_ok           = (gap_cnt == GAP_DONE);
  assign seq_hit          = held_valid && (req_word == next_word);
  assign unused_addr_bits = ^{flash_addr[31:24], flash_addr[1:0]};

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= S_IDLE;
      spi_cs_n   <= 1'b1;
      spi_sclk   <= 1'b0;
      spi_mosi   <= 1'b0;
      flash_ack  <= 1'b0;
      flash_data <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      cmd_sr     <= '0;
      rx_sr      <= '0;
      cur_word   <= '0;
      next_word  <= '0;
      held_valid <= 1'b0;
      idle_cnt   <= '0;
      gap_cnt    <= GAP_DONE;
    end else begin
      flash_ack <= 1'b0;
      // gap_cnt counts cycles spent with cs_n high, saturating once tSHSL is met
      if (spi_cs_n && !gap_ok)
        gap_cnt <= gap_cnt + 1'b1;

      case (state)
        S_IDLE, S_GAP: begin
          if (flash_cycle || state == S_GAP) begin
            if (gap_ok) begin
              spi_cs_n <= 1'b0;
              spi_mosi <= fresh_cmd[31];
              cmd_sr   <= fresh_cmd;
              bit_cnt  <= 6'd63;
              div_cnt  <= DIV_RELOAD;
              cur_word <= req_word;
              state    <= S_SHIFT;
            end else begin
              state <= S_GAP;
            end
          end
        end

        S_SHIFT: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
          end else begin
            div_cnt  <= DIV_RELOAD;
            spi_sclk <= ~spi_sclk;
            if (!spi_sclk) begin
              rx_sr <= {rx_sr[30:0], spi_miso};
            end else begin
              spi_mosi <= cmd_sr[30];
              cmd_sr   <= {cmd_sr[30:0], 1'b0};
              if (bit_cnt == '0) begin
                // first byte received sits in rx_sr[31:24]; it belongs in the low lane
                flash_data <= {rx_sr[7:0], rx_sr[15:8], rx_sr[23:16], rx_sr[31:24]};
                flash_ack  <= 1'b1;
                next_word  <= cur_word + 1'b1;
                held_valid <= 1'b1;
                state      <= S_ACK;
              end else begin
                bit_cnt <= bit_cnt - 1'b1;
              end
            end
          end
        end

        S_ACK: state <= S_DROP;

        S_DROP: begin
          if (!flash_cycle) begin
            idle_cnt <= IDLE_RELOAD;
            state    <= S_HELD;
          end
        end

        S_HELD: begin
          if (flash_cycle) begin
            idle_cnt <= IDLE_RELOAD;
            if (seq_hit) begin
              spi_mosi <= 1'b0;
              cmd_sr   <= '0;
              bit_cnt  <= 6'd31;
              div_cnt  <= DIV_RELOAD;
              cur_word <= req_word;
              state    <= S_SHIFT;
            end else begin
              spi_cs_n   <= 1'b1;
              held_valid <= 1'b0;
              gap_cnt    <= GAP_W'(1);
              state      <= S_GAP;
            end
          end else if (idle_cnt == '0) begin
            spi_cs_n   <= 1'b1;
            held_valid <= 1'b0;
            gap_cnt    <= GAP_W'(1);
            state      <= S_IDLE;
          end else begin
            idle_cnt <= idle_cnt - 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_spi_reader.sv
// Bench for flash_spi_reader: SPI-NOR flash model on the pads plus a timing/data
// reference model of the request port, driven by directed and random fetch streams.
module tb_flash_spi_reader;

  localparam int CLK_DIV     = 2;
  localparam int CS_IDLE_MAX = 16;
  localparam int CS_HIGH_MIN = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        flash_cycle = 1'b0;
  logic [31:0] flash_addr = '0;
  logic        flash_ack;
  logic [31:0] flash_data;
  logic        spi_sclk;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;

  flash_spi_reader #(
    .CLK_DIV(CLK_DIV), .CS_IDLE_MAX(CS_IDLE_MAX), .CS_HIGH_MIN(CS_HIGH_MIN)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .flash_cycle(flash_cycle),
    .flash_addr(flash_addr), .flash_ack(flash_ack), .flash_data(flash_data),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // flash contents: first four bytes fixed, the rest a cheap address hash
  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    if (a < 24'd4) return 8'h11 * (a[7:0] + 8'd1);
    return a[7:0] ^ a[15:8] ^ {a[20:16], a[23:21]} ^ 8'hA5;
  endfunction

  function automatic logic stream_bit(input logic [23:0] base, input int pos);
    logic [7:0] b;
    b = mem_byte(base + 24'(pos / 8));
    return b[7 - (pos % 8)];
  endfunction

  // pad monitor and flash model, sampled on the falling sys_clk edge
  logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;
  int          last_cs_fall = 0, last_cs_rise = 0, cs_rise_cnt = 0;
  int          n_rise = 0, total_rises = 0, mosi_bad = 0, s_pos = 0;
  logic [31:0] cmd_rx = '0;
  logic [23:0] s_base = '0;

  always @(negedge sys_clk) begin
    if (prev_cs && !spi_cs_n) begin last_cs_fall = cyc; n_rise = 0; end
    if (!prev_cs && spi_cs_n) begin last_cs_rise = cyc; cs_rise_cnt++; n_rise = 0; end
    if (prev_sclk && spi_sclk && (spi_mosi != prev_mosi)) mosi_bad++;
    if (!prev_sclk && spi_sclk && !spi_cs_n) begin
      if (n_rise < 32) cmd_rx = {cmd_rx[30:0], spi_mosi};
      else if (spi_mosi) mosi_bad++;
      n_rise++;
      total_rises++;
      if (n_rise == 32) begin s_base = cmd_rx[23:0]; s_pos = 0; end
    end
    if (prev_sclk && !spi_sclk && n_rise >= 32) begin
      spi_miso = stream_bit(s_base, s_pos);
      s_pos++;
    end
    prev_cs = spi_cs_n; prev_sclk = spi_sclk; prev_mosi = spi_mosi;
  end

  // reference model state
  bit          m_held = 0;
  logic [21:0] m_next_word = '0;
  int          m_held_at = 0;
  int          m_last_rise = -1000;
  int          rises_at_ack = 0, rise_cnt_at_ack = 0;
  int          g_req_s = 0, g_ack_cyc = 0;

  task automatic do_req(input logic [31:0] addr, input int gap, input bit drop_early);
    int s, fall, ack_exp, budget;
    bit fresh, expect_rise, got;
    logic [21:0] w;
    logic [23:0] a;
    logic [31:0] exp_data;
    repeat (gap) @(posedge sys_clk);
    #1;
    flash_addr  = addr;
    flash_cycle = 1'b1;
    s = cyc + 1;
    g_req_s = s;
    w = addr[23:2];
    a = {w, 2'b00};
    exp_data = {mem_byte(a + 24'd3), mem_byte(a + 24'd2), mem_byte(a + 24'd1), mem_byte(a)};
    fresh = 1; expect_rise = 0; fall = 0;
    if (m_held && s <= m_held_at + CS_IDLE_MAX) begin
      if (w == m_next_word) begin
        fresh = 0;
        ack_exp = s + 64 * CLK_DIV;
      end else begin
        expect_rise = 1;
        m_last_rise = s;
        fall = s + CS_HIGH_MIN;
        ack_exp = fall + 128 * CLK_DIV;
      end
    end else begin
      if (m_held) begin
        expect_rise = 1;
        m_last_rise = m_held_at + CS_IDLE_MAX;
      end
      fall = (s > m_last_rise + CS_HIGH_MIN) ? s : m_last_rise + CS_HIGH_MIN;
      ack_exp = fall + 128 * CLK_DIV;
    end
    budget = ack_exp - s + 40;
    got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge sys_clk);
      if (drop_early && i == 20) flash_cycle = 1'b0;
      if (flash_ack) got = 1;
    end
    flash_cycle = 1'b0;
    chk("ack_seen", got, 1);
    g_ack_cyc = cyc;
    chk("ack_cycle", cyc, ack_exp);
    chk("data", flash_data, exp_data);
    chk("sclk_rises", total_rises - rises_at_ack, fresh ? 64 : 32);
    if (fresh) begin
      chk("cs_fall", last_cs_fall, fall);
      chk("cmd", cmd_rx, {8'h03, w, 2'b00});
    end else begin
      chk("cs_stay_low", cs_rise_cnt, rise_cnt_at_ack);
    end
    if (expect_rise) chk("cs_rise", last_cs_rise, m_last_rise);
    chk("mosi_clean", mosi_bad, 0);
    m_held = 1;
    m_next_word = w + 22'd1;
    m_held_at = ack_exp + 2;
    rises_at_ack = total_rises;
    rise_cnt_at_ack = cs_rise_cnt;
    @(negedge sys_clk);
    chk("ack_pulse", flash_ack, 0);
    chk("data_hold", flash_data, exp_data);
  endtask

  initial begin
    #(900_000);
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rc, guard, g;
    logic [21:0] word;

    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    chk("rst_cs_n", spi_cs_n, 1);
    chk("rst_sclk", spi_sclk, 0);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_ack", flash_ack, 0);
    chk("rst_data", flash_data, 0);

    // first fresh read of word 0
    do_req(32'h0000_0000, 2, 0);
    chk("t1_cmd", cmd_rx, 32'h0300_0000);
    chk("t1_latency", g_ack_cyc - last_cs_fall, 256);
    chk("t1_data", flash_data, 32'h4433_2211);

    // boot-copy stream
    do_req(32'h0000_0004, 1, 0);
    chk("seq1_latency", g_ack_cyc - g_req_s, 128);
    do_req(32'h0000_0008, 1, 1);
    chk("seq2_latency", g_ack_cyc - g_req_s, 128);

    // out-of-sequence request from HELD
    do_req(32'h0000_3FFC, 1, 0);
    do_req(32'h0000_8000, 1, 0);
    chk("jump_cs_high", last_cs_fall - last_cs_rise, 4);
    chk("jump_cmd", cmd_rx, 32'h0300_8000);
    chk("jump_latency", g_ack_cyc - last_cs_fall, 256);

    // request on the timeout edge wins, one cycle later it does not
    do_req(32'h0000_8004, 16, 0);
    do_req(32'h0000_8008, 18, 0);
    chk("tmo_req_after_rise", g_req_s - last_cs_rise, 2);
    chk("tmo_cs_high", last_cs_fall - last_cs_rise, 4);

    // wrap from top of the 16 MB window
    do_req(32'h00FF_FFFC, 1, 0);
    do_req(32'h0000_0000, 1, 0);
    chk("wrap_data", flash_data, 32'h4433_2211);

    // reset in the middle of the data phase
    @(posedge sys_clk); #1;
    rc = cs_rise_cnt;
    flash_addr  = 32'h0000_0100;
    flash_cycle = 1'b1;
    guard = 0;
    while ((cs_rise_cnt == rc || spi_cs_n || n_rise < 41) && guard < 2000) begin
      @(negedge sys_clk);
      guard++;
    end
    chk("rst_mid_reached", (n_rise >= 41 && !spi_cs_n), 1);
    #2 sys_rst = 1'b1;
    #1;
    chk("rst_mid_cs_n", spi_cs_n, 1);
    chk("rst_mid_sclk", spi_sclk, 0);
    chk("rst_mid_mosi", spi_mosi, 0);
    chk("rst_mid_ack", flash_ack, 0);
    chk("rst_mid_data", flash_data, 0);
    flash_cycle = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    m_held = 0;
    m_last_rise = -1000;
    rises_at_ack = total_rises;
    rise_cnt_at_ack = cs_rise_cnt;
    do_req(32'h0000_0004, 2, 0);
    chk("post_rst_latency", g_ack_cyc - last_cs_fall, 256);

    // random mix of sequential and scattered fetches
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 9) < 6 && m_held) word = m_next_word;
      else word = 22'($urandom);
      case ($urandom_range(0, 5))
        0: g = 1;
        1: g = 3;
        2: g = 8;
        3: g = 16;
        4: g = 17;
        default: g = 22;
      endcase
      do_req({8'($urandom), word, 2'($urandom)}, g, ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/flash_spi_reader.md
Name: flash_spi_reader

Overview:
- SPI-NOR read controller that responds to the boot loader's flash request interface (flash_cycle/flash_addr in; flash_ack/flash_data out).
- Each request becomes a standard READ (0x03) transaction on an external SPI flash, and the block returns one 32-bit little-endian word.
- Sequential word reads (address + 4) keep chip-select low and skip the command phase, to speed up the bulk boot copy.
- Sits between the boot loader and the SPI flash pads.

Parameters:
- CLK_DIV, 2: sys_clk cycles per SCLK half-period; legal values ≥1.
- CS_IDLE_MAX, 16: cycles cs_n is held low with no request before it is released.
- CS_HIGH_MIN, 4: minimum sys_clk cycles cs_n stays high between transactions (tSHSL).

Ports:
- sys_clk  in  1  single clock; everything is synchronous to its rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- flash_cycle  in  1  request; held high by the requester until flash_ack, then dropped.
- flash_addr  in  32  byte address; only [23:2] used, [1:0] treated as 0.
- flash_ack  out  1  one-cycle pulse; flash_data is valid in this cycle.
- flash_data  out  32  read word; holds its value until the next ack.
- spi_sclk  out  1  SPI clock, mode 0 (idle low).
- spi_cs_n  out  1  chip select, active low.
- spi_mosi  out  1  serial out; changes only while spi_sclk is low.
- spi_miso  in  1  serial in; sampled on the sys_clk edge that drives spi_sclk high.

Behaviour:
- Reset (async, immediate, also mid-transfer): spi_cs_n=1, spi_sclk=0, spi_mosi=0, flash_ack=0, flash_data=0, state IDLE, CS-high counter = CS_HIGH_MIN (satisfied), held-address valid=0.
- States:
  - IDLE: cs_n high.
  - GAP: cs_n high, enforcing CS_HIGH_MIN.
  - SHIFT: serial transfer.
  - ACK: one cycle.
  - DROP: wait for flash_cycle low.
  - HELD: cs_n low, sclk low, awaiting a sequential request.
- IDLE → SHIFT (fresh): on flash_cycle=1 with the CS-high time satisfied.
  - At the accepting edge: spi_cs_n←0; latch {8'h03, addr[23:2], 2'b00} as the 32-bit command.
  - spi_mosi←command bit 31.
- IDLE → GAP: on flash_cycle=1 before CS_HIGH_MIN has elapsed since cs_n rose. Stay in GAP until the count completes, then start as above.
- SHIFT timing:
  - Each bit is CLK_DIV cycles with sclk low, then CLK_DIV cycles with sclk high.
  - Bit k sclk rise occurs CLK_DIV·(2k+1) cycles after cs_n fall or the continuation start.
  - mosi is updated on each sclk fall.
- Fresh transfer length: 64 bits (32 command/address, 32 data). Continuation: 32 data bits only.
- Data assembly:
  - Flash bytes arrive MSB-first.
  - Byte at addr → flash_data[7:0], addr+1 → [15:8], addr+2 → [23:16], addr+3 → [31:24].
  - mosi is don't-care (drive 0) during the data phase.
- SHIFT → ACK: on the edge where the final sclk falls.
  - flash_ack=1 for exactly one cycle and flash_data is updated.
  - Fresh latency: ack visible in the cycle beginning 128·CLK_DIV edges after cs_n fall.
  - Continuation latency: 64·CLK_DIV edges after HELD exit.
  - Record next_addr = (addr[23:2]+1) mod 2^22 (wraps 0xFFFFFC→0x000000).
- ACK → DROP. DROP → HELD once flash_cycle is sampled low; cs_n remains low. A new request is never accepted while in DROP.
- HELD, flash_cycle=1, addr[23:2]==next_addr: continuation; enter SHIFT with the data phase only, sclk first rise after CLK_DIV cycles.
- HELD, flash_cycle=1, address mismatch: cs_n←1 and enter GAP. cs_n stays high exactly CLK_DIV... no: exactly CS_HIGH_MIN cycles, then a fresh transfer.
- HELD, idle CS_IDLE_MAX consecutive cycles: cs_n←1 and enter IDLE (CS-high counter starts). The timeout counter clears on leaving HELD.
- Request sampled in the same cycle as timeout expiry: the request wins (continuation or mismatch rule applies).
- flash_cycle deasserted mid-SHIFT: ignored; the transfer completes and acks, then proceeds to DROP → HELD as usual.
- spi_sclk never glitches; all SPI outputs come directly from flops.

Test Plan:
- Reset, CLK_DIV=2; request addr 0x0000_0000, MISO model returns bytes 0x11,0x22,0x33,0x44:
  - mosi carries 0x03000000;
  - flash_ack pulses once 256 cycles after cs_n falls;
  - flash_data=0x44332211.
- Boot-loader-style stream 0x0, 0x4, 0x8:
  - only the first transfer has a command phase; cs_n stays low throughout;
  - second and third acks arrive 128 cycles after each request;
  - data match the model.
- In HELD, request 0x8000 after last 0x3FFC:
  - cs_n high for exactly 4 cycles;
  - new command 0x03008000;
  - ack after 256 cycles.
- No request for 16 cycles in HELD → cs_n rises. Request 2 cycles later → waits a further 2 cycles (CS_HIGH_MIN=4), then a fresh command.
- Assert sys_rst mid data phase (bit 40):
  - outputs return to reset values immediately;
  - a subsequent request to 0x4 performs a full fresh 64-bit transfer.
- Last ack at 0xFFFFFC, next request 0x000000 → continuation (no cs_n rise), data from flash byte 0.
